// File: rtl/pipe_control_unit.sv
// Registered decode-stage control unit: opcode decode, load-use interlock,
// post-branch squash sequencing and a circular return-address stack.
module pipe_control_unit #(
    parameter int OPC_W        = 4,
    parameter int RA_W         = 2,
    parameter int PC_W         = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic [RA_W-1:0]  ra,
    input  logic [RA_W-1:0]  rb,
    input  logic             Z,
    input  logic             N,
    input  logic             BRX,
    input  logic [PC_W-1:0]  pc_plus1,
    input  logic             ex_mem_r_en,
    input  logic [RA_W-1:0]  ex_rd,
    output logic             WB_EN,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic             B,
    output logic             S,
    output logic             Ret,
    output logic             L,
    output logic             IMM,
    output logic             SRC1,
    output logic             SRC2,
    output logic             inPort,
    output logic             outPort,
    output logic [3:0]       EXE_CMD,
    output logic             ctrl_valid,
    output logic             stall,
    output logic             flush,
    output logic [PC_W-1:0]  ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow,
    output logic             illegal_op
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, FLUSH} state_e;

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic       ret;
        logic       l;
        logic       imm;
        logic       src1;
        logic       src2;
        logic       in_port;
        logic       out_port;
        logic [3:0] exe_cmd;
    } bundle_t;

    state_e          state_q, state_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [PC_W-1:0] ras_d [RAS_DEPTH];
    logic [PC_W-1:0] top_q, top_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            ill_q, ill_d;
    bundle_t         bun_q, bun_d;

    bundle_t    dec;
    logic       illegal;
    logic [3:0] op;
    logic       hz;
    logic       accept;

    always_comb begin
        dec     = '0;
        illegal = (opcode >> 4) != '0;
        op      = opcode[3:0];
        if (!illegal) begin
            unique case (op)
                4'h1, 4'h2, 4'h3: begin
                    dec.wb_en   = 1'b1;
                    dec.s       = 1'b1;
                    dec.src1    = 1'b1;
                    dec.src2    = 1'b1;
                    dec.exe_cmd = op;
                end
                4'h4, 4'h5: begin
                    dec.wb_en   = 1'b1;
                    dec.s       = 1'b1;
                    dec.src1    = 1'b1;
                    dec.exe_cmd = op;
                end
                4'h6: begin
                    dec.out_port = 1'b1;
                    dec.src1     = 1'b1;
                    dec.exe_cmd  = op;
                end
                4'h7: begin
                    dec.wb_en   = 1'b1;
                    dec.in_port = 1'b1;
                    dec.src1    = 1'b1;
                    dec.exe_cmd = op;
                end
                4'h8: begin
                    dec.wb_en   = 1'b1;
                    dec.src1    = 1'b1;
                    dec.exe_cmd = op;
                end
                4'h9: dec.b = 1'b1;
                4'hA: dec.b = BRX ? N : Z;
                4'hB: begin
                    dec.b = 1'b1;
                    dec.l = 1'b1;
                end
                4'hC: begin
                    dec.b   = 1'b1;
                    dec.ret = 1'b1;
                end
                4'hD: begin
                    dec.wb_en    = 1'b1;
                    dec.mem_r_en = 1'b1;
                    dec.imm      = 1'b1;
                    dec.exe_cmd  = 4'h8;
                end
                4'hE: begin
                    dec.mem_w_en = 1'b1;
                    dec.imm      = 1'b1;
                    dec.exe_cmd  = 4'h8;
                end
                4'hF: begin
                    dec.wb_en   = 1'b1;
                    dec.imm     = 1'b1;
                    dec.exe_cmd = 4'h8;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hz = id_valid & ex_mem_r_en &
             ((dec.src1 & (ra == ex_rd)) | (dec.src2 & (rb == ex_rd)));
        stall  = hz & (state_q == RUN);
        accept = (state_q == RUN) & id_valid & ~hz;
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ras_d   = ras_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ill_d   = ill_q;
        bun_d   = '0;
        if (state_q == FLUSH) begin
            fcnt_d = fcnt_q - 4'd1;
            if (fcnt_q == 4'd1) state_d = RUN;
        end else if (accept) begin
            bun_d       = dec;
            bun_d.valid = 1'b1;
            if (illegal) ill_d = 1'b1;
            if (dec.b) begin
                state_d = FLUSH;
                fcnt_d  = 4'(FLUSH_CYCLES);
            end
            if (dec.l) begin
                // When full, ptr already addresses the oldest entry.
                ras_d[ptr_q] = pc_plus1;
                ptr_d        = ptr_q + PTR_W'(1);
                if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            if (dec.ret) begin
                if (cnt_q == '0) begin
                    top_d = '0;
                    unf_d = 1'b1;
                end else begin
                    top_d = ras_q[ptr_q - PTR_W'(1)];
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
            bun_q   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ill_q   <= ill_d;
            bun_q   <= bun_d;
            ras_q   <= ras_d;
        end
    end

    assign WB_EN         = bun_q.wb_en;
    assign MEM_R_EN      = bun_q.mem_r_en;
    assign MEM_W_EN      = bun_q.mem_w_en;
    assign B             = bun_q.b;
    assign S             = bun_q.s;
    assign Ret           = bun_q.ret;
    assign L             = bun_q.l;
    assign IMM           = bun_q.imm;
    assign SRC1          = bun_q.src1;
    assign SRC2          = bun_q.src2;
    assign inPort        = bun_q.in_port;
    assign outPort       = bun_q.out_port;
    assign EXE_CMD       = bun_q.exe_cmd;
    assign ctrl_valid    = bun_q.valid;
    assign flush         = (state_q == FLUSH);
    assign ras_top       = top_q;
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign illegal_op    = ill_q;

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Registered decode-stage control unit for the 4-stage RISC pipeline; generalises the opcode decoder to OPC_W-bit opcodes.
- Adds a load-use interlock, post-branch flush sequencing and a return-address stack (RAS) for BR.SUB/RET.
- Sits between the ID stage and the ID/EX register and drives the complete control bundle into EX one cycle after decode.

Parameters:
- OPC_W, 4: opcode width, ≥4; opcodes with any bit above bit 3 set are illegal.
- RA_W, 2: register address width.
- PC_W, 8: program counter width.
- FLUSH_CYCLES, 2: instructions squashed after a taken branch, 1..15.
- RAS_DEPTH, 4: return-address stack entries, power of 2, ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- opcode  in  OPC_W  instruction opcode
- ra  in  RA_W  source register 1
- rb  in  RA_W  source register 2
- Z  in  1  zero flag
- N  in  1  negative flag
- BRX  in  1  conditional-branch select: 0 = Z, 1 = N
- pc_plus1  in  PC_W  address of the next instruction
- ex_mem_r_en  in  1  instruction in EX is a load
- ex_rd  in  RA_W  destination register of that load
- WB_EN, MEM_R_EN, MEM_W_EN, B, S, Ret, L, IMM, SRC1, SRC2, inPort, outPort  out  1 each  registered control bundle
- EXE_CMD  out  4  registered ALU command
- ctrl_valid  out  1  bundle carries a real instruction
- stall  out  1  combinational; freezes PC and IF/ID
- flush  out  1  registered; squash window active
- ras_top  out  PC_W  return target, registered with Ret
- ras_empty  out  1  RAS empty
- ras_full  out  1  RAS full
- ras_overflow  out  1  sticky overflow flag
- ras_underflow  out  1  sticky underflow flag
- illegal_op  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0, except ras_empty=1.
  - State RUN; flush counter 0; RAS pointer 0; count 0; sticky flags cleared.
  - Reset mid-flush or mid-stall returns to RUN immediately.
- Decode (combinational, internal): opcodes 0000–1111 map as follows.
  - WB_EN: 0001–0101, 0111, 1000, 1101, 1111.
  - MEM_R_EN: 1101. MEM_W_EN: 1110.
  - S: 0001–0101. SRC1: 0001–1000. SRC2: 0001–0011.
  - IMM: 1101, 1110, 1111. L: 1011. Ret: 1100.
  - inPort: 0111. outPort: 0110.
  - EXE_CMD: the opcode itself for 0001–1000; 1000 (MOV) for 1101–1111; 0000 otherwise.
  - B: 1001, 1011, 1100, or 1010 when (BRX=0 and Z=1) or (BRX=1 and N=1).
- Illegal opcode: decodes as NOP, sets illegal_op (sticky until reset).
- Latency: the bundle appears on the clk edge after the instruction is in ID, provided it is accepted (not stalled, not squashed).
- Bubble: all bundle bits 0, EXE_CMD=0000, ctrl_valid=0.
- Hazard:
  - hz = id_valid & ex_mem_r_en & ((SRC1 & ra==ex_rd) | (SRC2 & rb==ex_rd)).
  - stall = hz & state==RUN.
  - When stall=1, a bubble is registered and the RAS is untouched.
- FSM:
  - RUN: accept an instruction when id_valid and no stall. A taken branch (B=1) moves to FLUSH and loads cnt=FLUSH_CYCLES.
  - FLUSH: flush=1. Each cycle registers a bubble regardless of id_valid or hz; stall=0; cnt decrements. When cnt reaches 1, next state is RUN.
- Flush priority: flush has priority over stall. Squashed instructions never touch the RAS or the sticky flags.
- RAS as a circular buffer:
  - Push on accepted L: write pc_plus1 at ptr, then ptr+1 (mod RAS_DEPTH).
  - Push when full: overwrites the oldest entry, count stays at RAS_DEPTH, sets ras_overflow.
  - Pop on accepted Ret: ras_top ← entry[ptr-1], ptr-1, count-1.
  - Pop when empty: ras_top ← 0, ptr and count unchanged, sets ras_underflow; B is still 1.
  - ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
- id_valid=0 in RUN: registers a bubble; no state change.

Test Plan:
- Reset, then opcode=0001, id_valid=1 → next edge: WB_EN=S=SRC1=SRC2=1, EXE_CMD=0001, ctrl_valid=1; other bits 0.
- ex_mem_r_en=1, ex_rd=2, opcode=0010, rb=2 → stall=1 that cycle, bubble registered. Drop ex_mem_r_en → SUB issued next edge.
- opcode=1010, BRX=1, N=1, FLUSH_CYCLES=2 → B=1, then flush=1 for 2 cycles with bubbles even with id_valid=1 and a hazard present; back to RUN.
- 1010 with BRX=0, Z=0 → B=0; no flush.
- Push 5 BR.SUB with pc_plus1=10..14 at RAS_DEPTH=4 → ras_overflow=1. Four RETs give ras_top=14,13,12,11. A fifth RET gives ras_top=0 and ras_underflow=1.
- OPC_W=5, opcode=10001 → NOP bundle, illegal_op=1. Assert rst_n=0 during a flush window → all outputs 0 and state RUN on the next edge.
